// File: rtl/control_unit_pkg.sv
// Shared types and constants for the instruction-sequencing control unit.
package control_unit_pkg;

  localparam int unsigned IW   = 16;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RAW  = 4;
  localparam int unsigned DAW  = 8;
  localparam int unsigned SW   = 4;
  localparam int unsigned ALUW = 3;

  // Instruction field positions
  localparam int unsigned OP_LSB      = 12;
  localparam int unsigned RA_LSB      = 8;
  localparam int unsigned RB_LSB      = 4;
  localparam int unsigned RD_LSB      = 0;
  localparam int unsigned LD_ADDR_LSB = 4;
  localparam int unsigned ST_ADDR_LSB = 0;

  typedef enum logic [OPW-1:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_e;

  typedef enum logic [SW-1:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  localparam logic [ALUW-1:0] ALU_PASS = 3'b000;
  localparam logic [ALUW-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALUW-1:0] ALU_SUB  = 3'b010;

  // Extract the opcode field of an instruction word
  function automatic logic [OPW-1:0] get_opcode(input logic [IW-1:0] w);
    return w[OP_LSB +: OPW];
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the control unit, instruction ROM, PC and datapath.
interface control_unit_if
  import control_unit_pkg::*;
();

  logic [IW-1:0]   instr;
  logic            PC_clr;
  logic            PC_up;
  logic [IW-1:0]   IR;
  logic [DAW-1:0]  D_addr;
  logic            D_wr;
  logic            RF_s;
  logic [RAW-1:0]  RF_W_addr;
  logic            RF_W_en;
  logic [RAW-1:0]  RF_Ra_addr;
  logic [RAW-1:0]  RF_Rb_addr;
  logic [ALUW-1:0] ALU_s0;
  logic [SW-1:0]   state;

  modport master (
    input  instr,
    output PC_clr, PC_up, IR, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, state
  );

  modport slave (
    output instr,
    input  PC_clr, PC_up, IR, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, state
  );

endinterface

// File: rtl/control_unit_ir_reg.sv
// Instruction register: synchronous clear, loads on enable.
module control_unit_ir_reg
  import control_unit_pkg::*;
(
  input  logic          Clk,
  input  logic          Clr,
  input  logic          load,
  input  logic [IW-1:0] d,
  output logic [IW-1:0] q
);

  // Clear dominates load
  always_ff @(posedge Clk) begin
    if (Clr)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetch, decode and multi-cycle execute control.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           Clk,
  input  logic           Clr,
  control_unit_if.master bus
);

  state_e          state_q;
  state_e          state_d;
  logic [IW-1:0]   ir_q;
  logic            ir_load;

  logic            pc_clr;
  logic            pc_up;
  logic [DAW-1:0]  d_addr;
  logic            d_wr;
  logic            rf_s;
  logic [RAW-1:0]  rf_w_addr;
  logic            rf_w_en;
  logic [RAW-1:0]  rf_ra_addr;
  logic [RAW-1:0]  rf_rb_addr;
  logic [ALUW-1:0] alu_s0;

  assign ir_load = (state_q == S_FETCH);

  control_unit_ir_reg u_ir_reg (
    .Clk  (Clk),
    .Clr  (Clr),
    .load (ir_load),
    .d    (bus.instr),
    .q    (ir_q)
  );

  // State register; Clr overrides any transition
  always_ff @(posedge Clk) begin
    if (Clr) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Next-state logic; DECODE branches on the captured opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (get_opcode(ir_q))
          OP_LOAD:  state_d = S_LOAD_A;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Moore output decode from state and IR; unused fields held at zero
  always_comb begin
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_s0     = ALU_PASS;
    case (state_q)
      S_INIT:  pc_clr = 1'b1;
      S_FETCH: pc_up  = 1'b1;
      S_LOAD_A, S_LOAD_B: begin
        d_addr    = ir_q[LD_ADDR_LSB +: DAW];
        rf_s      = 1'b1;
        rf_w_addr = ir_q[RD_LSB +: RAW];
        rf_w_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        d_addr     = ir_q[ST_ADDR_LSB +: DAW];
        rf_ra_addr = ir_q[RA_LSB +: RAW];
        d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = ir_q[RA_LSB +: RAW];
        rf_rb_addr = ir_q[RB_LSB +: RAW];
        rf_w_addr  = ir_q[RD_LSB +: RAW];
        rf_w_en    = 1'b1;
        alu_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign bus.PC_clr     = pc_clr;
  assign bus.PC_up      = pc_up;
  assign bus.IR         = ir_q;
  assign bus.D_addr     = d_addr;
  assign bus.D_wr       = d_wr;
  assign bus.RF_s       = rf_s;
  assign bus.RF_W_addr  = rf_w_addr;
  assign bus.RF_W_en    = rf_w_en;
  assign bus.RF_Ra_addr = rf_ra_addr;
  assign bus.RF_Rb_addr = rf_rb_addr;
  assign bus.ALU_s0     = alu_s0;
  assign bus.state      = state_q;

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM for the single-cycle-ROM processor. Drives the program counter's clear/increment strobes, captures each 16-bit instruction into an internal instruction register, decodes it, and sequences data-memory, register-file and ALU controls across multi-cycle LOAD/STORE/ADD/SUB/HALT execution. Sits directly upstream of the program counter and beside the datapath, which it controls.

## Interface
- IW, 16, instruction width
- OPW, 4, opcode width (instr[15:12])
- RAW, 4, register-file address width
- DAW, 8, data-memory address width
- Clk  input  1  system clock; all state changes on rising edge
- Clr  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- instr  input  IW  instruction-ROM output for the current PC address
- PC_clr  output  1  clear strobe to program counter
- PC_up  output  1  increment strobe to program counter
- IR  output  IW  instruction register contents
- D_addr  output  DAW  data-memory address
- D_wr  output  1  data-memory write enable
- RF_s  output  1  register-file write-data select (1 = data memory, 0 = ALU)
- RF_W_addr  output  RAW  register-file write address
- RF_W_en  output  1  register-file write enable
- RF_Ra_addr, RF_Rb_addr  output  RAW each  register-file read addresses
- ALU_s0  output  3  ALU function select
- state  output  4  current state encoding, debug

## Operation
- Encoding: NOOP 0000, STORE 0001, LOAD 0010, ADD 0011, SUB 0100, HALT 0101; others execute as NOOP.
- Fields: LOAD instr[11:4]=D_addr, [3:0]=Rd; STORE [11:8]=Ra, [7:0]=D_addr; ADD/SUB [11:8]=Ra, [7:4]=Rb, [3:0]=Rd.
- States: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT. Moore outputs, decoded from state and IR only.
- INIT: PC_clr=1 -> FETCH.
- FETCH: IR <= instr, PC_up=1 -> DECODE.
- DECODE: no strobes; branch on IR[15:12]: LOAD->LOAD_A, STORE->STORE, ADD->ADD, SUB->SUB, HALT->HALT, else FETCH.
- LOAD_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0] -> LOAD_B. LOAD_B: same plus RF_W_en=1 -> FETCH.
- STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1 -> FETCH.
- ADD/SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=001 (ADD) / 010 (SUB) -> FETCH.
- HALT: all strobes 0; remains until Clr.
- Fields not used by a state drive 0; ALU_s0 defaults 000.

## Timing
- Clr=1 at a rising edge: state<=INIT, IR<=0, overriding any transition, including mid-LOAD or during HALT. While Clr held, state stays INIT, PC_clr=1, every other output 0.
- First FETCH one cycle after Clr deasserts; PC reaches 0 the same edge FETCH is entered.
- instr must be valid during FETCH (ROM addressed by PC for ≥1 cycle since INIT or previous PC_up).
- PC_up asserted exactly one cycle per instruction; the PC increments on the edge leaving FETCH.
- Cycles per instruction including FETCH+DECODE: NOOP/unknown 2, STORE/ADD/SUB 3, LOAD 4.
- D_wr and RF_W_en never asserted in the same cycle; neither asserted in INIT/FETCH/DECODE/HALT.
- PC wrap (7-bit) is the program counter's concern; control unit keeps fetching.

## Structure
- proc_pkg: opcode enum, state enum (4-bit), ALU select constants (ALU_PASS=000, ALU_ADD=001, ALU_SUB=010), field-position localparams.
- One sub-module natural: ir_reg (IW-bit register with synchronous Clr and load enable), instantiated with load = (state==FETCH).
- Next-state logic in always_comb, state register in always_ff, output decode in a separate always_comb.

## Test plan
- Clr held 3 cycles then released -> state INIT with PC_clr=1 throughout, FETCH next cycle with PC_up=1, all other outputs 0.
- instr=0x2A35 (LOAD) -> DECODE, LOAD_A then LOAD_B with D_addr=0xA3, RF_W_addr=5, RF_s=1; RF_W_en=1 only in LOAD_B; back to FETCH (4 cycles total).
- instr=0x1407 (STORE) -> STORE cycle with D_wr=1, D_addr=0x07, RF_Ra_addr=4; instr=0x3126 (ADD) -> RF_Ra=1, RF_Rb=2, RF_W_addr=6, ALU_s0=001, RF_W_en=1; 0x4126 same with ALU_s0=010.
- instr=0x5000 (HALT) -> HALT held 20 cycles with PC_up=0, D_wr=0, RF_W_en=0; Clr pulse -> INIT.
- instr=0xF123 (unknown) -> FETCH→DECODE→FETCH, no write strobes; PC_up count equals instructions fetched.
- Clr asserted during LOAD_A -> next state INIT, RF_W_en never asserted, IR=0.
